// File: rtl/key_press_pulser.sv
// key_press_pulser
//
// Turns a raw, bouncy, active-low push-button (key_n) into a clean debounced
// level (pressed) and a single-cycle strobe (pulse) for each accepted press.
// The pulse feeds the increment enable of the downstream enable counter, so
// that counter advances once per physical press.
//
// Structure:
//   key_n -> s1 -> s2        two-flop synchronizer, only s2 is used downstream
//   s2    -> stability counter -> debounced state (pressed)
//   debounced rise           -> registered one-cycle pulse
//
// Optional build macro KEY_PRESS_PULSER_AUTOREPEAT_EN:
//   When defined, holding the key produces extra pulses REPEAT_DELAY cycles
//   after the press pulse and every REPEAT_PERIOD cycles after that. When
//   undefined, the repeat logic is absent and REPEAT_DELAY / REPEAT_PERIOD
//   only take part in the parameter legality check.

module key_press_pulser #(
  parameter int STABLE_CYCLES = 50000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic pressed,
  output logic pulse
);

  // ---------------------------------------------------------------------------
  // Parameter legality
  // ---------------------------------------------------------------------------
  localparam bit PARAMS_OK = (STABLE_CYCLES >= 2) &&
                             (REPEAT_DELAY  >= 1) &&
                             (REPEAT_PERIOD >= 1);

  if (!PARAMS_OK) begin : g_bad_params
    $error("key_press_pulser: STABLE_CYCLES must be >= 2, REPEAT_DELAY and REPEAT_PERIOD >= 1");
  end

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  localparam int                CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {
    ST_RELEASED = 1'b0,
    ST_PRESSED  = 1'b1
  } db_state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer
  // ---------------------------------------------------------------------------
  logic s1;
  logic s2;

  // Bring the asynchronous key into the clk domain; both flops reset to released.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make s2 take the previous s1, giving two
      // real flop stages; blocking here would collapse the chain to one flop.
      s1 <= key_n;
      s2 <= s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: stability counter and debounced state
  // ---------------------------------------------------------------------------
  db_state_t        state;
  logic [CNT_W-1:0] stable_cnt;

  logic s2_pressed;  // synchronized key in "1 = held" polarity
  logic differs;     // synchronized key disagrees with the debounced state
  logic flip;        // this edge completes the required run of disagreement
  logic rise;        // released -> pressed on this edge
  logic fall;        // pressed -> released on this edge

  assign s2_pressed = ~s2;
  assign differs    = (s2_pressed != (state == ST_PRESSED));
  assign flip       = differs && (stable_cnt == CNT_LAST);
  assign rise       = flip && (state == ST_RELEASED);
  assign fall       = flip && (state == ST_PRESSED);

  // Count consecutive cycles of disagreement; any agreement restarts the count,
  // and reaching STABLE_CYCLES flips the debounced state and clears the count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_RELEASED;
      stable_cnt <= '0;
    end else if (!differs) begin
      stable_cnt <= '0;
    end else if (flip) begin
      state      <= (state == ST_PRESSED) ? ST_RELEASED : ST_PRESSED;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + CNT_W'(1);
    end
  end

  // The debounced state is itself a flop, so pressed is a registered output.
  assign pressed = (state == ST_PRESSED);

  // ---------------------------------------------------------------------------
  // Pulse generation
  // ---------------------------------------------------------------------------
`ifdef KEY_PRESS_PULSER_AUTOREPEAT_EN

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt;     // cycles since the last press/repeat pulse, minus one
  logic             rpt_first;   // next repeat is the first one (uses REPEAT_DELAY)
  logic [RPT_W-1:0] rpt_target;
  logic             rpt_fire;

  assign rpt_target = rpt_first ? RPT_DELAY_LAST : RPT_PERIOD_LAST;
  assign rpt_fire   = (state == ST_PRESSED) && !fall && (rpt_cnt == rpt_target);

  // Press pulse on the debounced rise; while held, repeat pulses after
  // REPEAT_DELAY and then every REPEAT_PERIOD. The count restarts on each
  // press and is held clear while released.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pulse     <= 1'b0;
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else begin
      pulse <= rise || rpt_fire;
      if (rise || fall || (state != ST_PRESSED)) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b1;
      end else if (rpt_fire) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b0;
      end else begin
        rpt_cnt   <= rpt_cnt + RPT_W'(1);
      end
    end
  end

`else

  // One registered strobe per debounced rise, coincident with pressed rising;
  // the release produces none.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pulse <= 1'b0;
    end else begin
      pulse <= rise;
    end
  end

`endif

endmodule
